// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch looks up combinationally; execute trains the table and flags mispredicts.
module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN-1:0]     pc_fetch,
  output logic                predict_taken,
  output logic [XLEN-1:0]     predict_pc,
  input  logic                update_valid,
  input  logic                is_jump_execute,
  input  logic [XLEN-1:0]     pc_execute,
  input  logic                taken_execute,
  input  logic [XLEN-1:0]     target_execute,
  input  logic                predicted_taken_execute,
  input  logic [XLEN-1:0]     predicted_pc_execute,
  output logic                mispredict,
  output logic [CNT_BITS-1:0] branch_count,
  output logic [CNT_BITS-1:0] mispredict_count
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  // update_valid is a single-cycle strobe with no backpressure: the table
  // always accepts the resolved branch on the edge where update_valid is 1.

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX-1:0]   fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic             fetch_hit;
  logic [IDX-1:0]   exec_idx;
  logic [TAG_W-1:0] exec_tag;
  logic             exec_hit;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pc_fetch[1:0], pc_execute[1:0]};

  assign fetch_idx = pc_fetch[IDX+1:2];
  assign fetch_tag = pc_fetch[XLEN-1:IDX+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign predict_taken = fetch_hit && ctr_q[fetch_idx][1];
  assign predict_pc    = predict_taken ? target_q[fetch_idx] : pc_fetch + XLEN'(4);

  assign exec_idx = pc_execute[IDX+1:2];
  assign exec_tag = pc_execute[XLEN-1:IDX+2];
  assign exec_hit = valid_q[exec_idx] && (tag_q[exec_idx] == exec_tag);

  // A taken branch that was predicted taken still mispredicts if the carried
  // target differs, which covers JALR targets that moved.
  assign mispredict = update_valid &&
                      ((predicted_taken_execute != taken_execute) ||
                       (taken_execute && (predicted_pc_execute != target_execute)));

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'd3) ? 2'd3 : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  // Targets and tags are left untouched by reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'd1;
      end
    end else if (update_valid) begin
      if (exec_hit) begin
        if (is_jump_execute) begin
          ctr_q[exec_idx]    <= 2'd3;
          target_q[exec_idx] <= target_execute;
        end else if (taken_execute) begin
          ctr_q[exec_idx]    <= sat_inc(ctr_q[exec_idx]);
          target_q[exec_idx] <= target_execute;
        end else begin
          ctr_q[exec_idx]    <= sat_dec(ctr_q[exec_idx]);
        end
      end else if (taken_execute) begin
        valid_q[exec_idx]  <= 1'b1;
        tag_q[exec_idx]    <= exec_tag;
        target_q[exec_idx] <= target_execute;
        ctr_q[exec_idx]    <= is_jump_execute ? 2'd3 : 2'd2;
      end
    end
  end

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_valid && (branch_count != CNT_MAX))
        branch_count <= branch_count + CNT_BITS'(1);
      if (mispredict && (mispredict_count != CNT_MAX))
        mispredict_count <= mispredict_count + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a default instance plus a
// CNT_BITS=4 instance sharing the same stimulus for counter saturation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_fetch;
  logic        update_valid;
  logic        is_jump_execute;
  logic [31:0] pc_execute;
  logic        taken_execute;
  logic [31:0] target_execute;
  logic        predicted_taken_execute;
  logic [31:0] predicted_pc_execute;

  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  logic        predict_taken_s;
  logic [31:0] predict_pc_s;
  logic        mispredict_s;
  logic [3:0]  branch_count_s;
  logic [3:0]  mispredict_count_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_BITS(32)) dut (
    .clk(clk), .reset(reset), .pc_fetch(pc_fetch),
    .predict_taken(predict_taken), .predict_pc(predict_pc),
    .update_valid(update_valid), .is_jump_execute(is_jump_execute),
    .pc_execute(pc_execute), .taken_execute(taken_execute),
    .target_execute(target_execute),
    .predicted_taken_execute(predicted_taken_execute),
    .predicted_pc_execute(predicted_pc_execute),
    .mispredict(mispredict), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CNT_BITS(4)) dut_small (
    .clk(clk), .reset(reset), .pc_fetch(pc_fetch),
    .predict_taken(predict_taken_s), .predict_pc(predict_pc_s),
    .update_valid(update_valid), .is_jump_execute(is_jump_execute),
    .pc_execute(pc_execute), .taken_execute(taken_execute),
    .target_execute(target_execute),
    .predicted_taken_execute(predicted_taken_execute),
    .predicted_pc_execute(predicted_pc_execute),
    .mispredict(mispredict_s), .branch_count(branch_count_s),
    .mispredict_count(mispredict_count_s)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic jmp, input logic ptk, input logic [31:0] ppc);
    update_valid            = 1'b1;
    pc_execute              = pc;
    taken_execute           = tk;
    target_execute          = tgt;
    is_jump_execute         = jmp;
    predicted_taken_execute = ptk;
    predicted_pc_execute    = ppc;
  endtask

  task automatic idle_update();
    update_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    idle_update();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pc_fetch = pc;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL cold_taken: got %0b want 0", predict_taken);
    end
    n_checks++;
    if (predict_pc !== 32'h104) begin
      n_fail++; $display("FAIL cold_pc: got %h want 00000104", predict_pc);
    end
    n_checks++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      n_fail++; $display("FAIL cold_counts: got %0d/%0d want 0/0", branch_count, mispredict_count);
    end
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL cold_mispredict: got %0b want 0", mispredict);
    end
  endtask

  task automatic test_allocate();
    drive_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    #1;
    n_checks++;
    if (mispredict !== 1'b1) begin
      n_fail++; $display("FAIL alloc_mispredict: got %0b want 1", mispredict);
    end
    step();
    idle_update();
    lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b1 || predict_pc !== 32'h80) begin
      n_fail++; $display("FAIL alloc_hit: got %0b/%h want 1/00000080", predict_taken, predict_pc);
    end
    n_checks++;
    if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
      n_fail++; $display("FAIL alloc_counts: got %0d/%0d want 1/1", branch_count, mispredict_count);
    end
  endtask

  // Entry 0x100 starts weak-T from test_allocate.
  task automatic test_hysteresis();
    drive_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    step(); idle_update(); lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL hyst_nt1: got %0b want 0", predict_taken);
    end
    drive_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    step(); idle_update(); lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL hyst_t1: got %0b want 1", predict_taken);
    end
    for (int i = 0; i < 3; i++) begin
      drive_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80);
      #1;
      n_checks++;
      if (mispredict !== 1'b0) begin
        n_fail++; $display("FAIL hyst_correct_%0d: got %0b want 0", i, mispredict);
      end
      step();
    end
    drive_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    step(); idle_update(); lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL hyst_sat_nt1: got %0b want 1", predict_taken);
    end
    drive_update(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
    step(); idle_update(); lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b0 || predict_pc !== 32'h104) begin
      n_fail++; $display("FAIL hyst_sat_nt2: got %0b/%h want 0/00000104", predict_taken, predict_pc);
    end
    n_checks++;
    if (branch_count !== 32'd8 || mispredict_count !== 32'd5) begin
      n_fail++; $display("FAIL hyst_counts: got %0d/%0d want 8/5", branch_count, mispredict_count);
    end
  endtask

  task automatic test_aliasing();
    apply_reset();
    drive_update(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h104);
    step();
    drive_update(32'h140, 1'b1, 32'h90, 1'b0, 1'b0, 32'h144);
    step(); idle_update();
    lookup(32'h100);
    n_checks++;
    if (predict_taken !== 1'b0 || predict_pc !== 32'h104) begin
      n_fail++; $display("FAIL alias_evicted: got %0b/%h want 0/00000104", predict_taken, predict_pc);
    end
    lookup(32'h140);
    n_checks++;
    if (predict_taken !== 1'b1 || predict_pc !== 32'h90) begin
      n_fail++; $display("FAIL alias_resident: got %0b/%h want 1/00000090", predict_taken, predict_pc);
    end
  endtask

  task automatic test_jump();
    drive_update(32'h200, 1'b1, 32'h300, 1'b1, 1'b0, 32'h204);
    step(); idle_update(); lookup(32'h200);
    n_checks++;
    if (predict_taken !== 1'b1 || predict_pc !== 32'h300) begin
      n_fail++; $display("FAIL jal_alloc: got %0b/%h want 1/00000300", predict_taken, predict_pc);
    end
    drive_update(32'h200, 1'b1, 32'h400, 1'b1, 1'b1, 32'h300);
    #1;
    n_checks++;
    if (mispredict !== 1'b1) begin
      n_fail++; $display("FAIL jalr_mispredict: got %0b want 1", mispredict);
    end
    // Same-cycle lookup sees the old target; no bypass.
    n_checks++;
    if (predict_pc !== 32'h300) begin
      n_fail++; $display("FAIL no_bypass: got %h want 00000300", predict_pc);
    end
    step(); idle_update(); lookup(32'h200);
    n_checks++;
    if (predict_taken !== 1'b1 || predict_pc !== 32'h400) begin
      n_fail++; $display("FAIL jalr_retarget: got %0b/%h want 1/00000400", predict_taken, predict_pc);
    end
    // ctr must be 3: one not-taken leaves it predicting taken.
    drive_update(32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400);
    step(); idle_update(); lookup(32'h200);
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL jump_ctr3: got %0b want 1", predict_taken);
    end
    // Mismatched carried inputs without update_valid never flag.
    drive_update(32'h200, 1'b1, 32'h500, 1'b0, 1'b0, 32'h204);
    idle_update();
    #1;
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL mispredict_gated: got %0b want 0", mispredict);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      drive_update(32'h500, 1'b1, 32'h600, 1'b0, 1'b0, 32'h504);
      step();
    end
    idle_update();
    #1;
    n_checks++;
    if (branch_count_s !== 4'd15 || mispredict_count_s !== 4'd15) begin
      n_fail++; $display("FAIL sat_small: got %0d/%0d want 15/15", branch_count_s, mispredict_count_s);
    end
    n_checks++;
    if (branch_count !== 32'd20 || mispredict_count !== 32'd20) begin
      n_fail++; $display("FAIL sat_wide: got %0d/%0d want 20/20", branch_count, mispredict_count);
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1;
    drive_update(32'h600, 1'b1, 32'h700, 1'b1, 1'b0, 32'h604);
    step();
    reset = 1'b0;
    idle_update();
    lookup(32'h600);
    n_checks++;
    if (predict_taken !== 1'b0 || predict_pc !== 32'h604) begin
      n_fail++; $display("FAIL reset_prio_table: got %0b/%h want 0/00000604", predict_taken, predict_pc);
    end
    lookup(32'h500);
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL reset_discards: got %0b want 0", predict_taken);
    end
    n_checks++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0 ||
        branch_count_s !== 4'd0 || mispredict_count_s !== 4'd0) begin
      n_fail++; $display("FAIL reset_prio_counts: got %0d/%0d/%0d/%0d want 0/0/0/0",
                         branch_count, mispredict_count, branch_count_s, mispredict_count_s);
    end
  endtask

  task automatic test_wrap();
    lookup(32'hFFFF_FFFC);
    n_checks++;
    if (predict_taken !== 1'b0 || predict_pc !== 32'h0) begin
      n_fail++; $display("FAIL pc_wrap: got %0b/%h want 0/00000000", predict_taken, predict_pc);
    end
  endtask

  initial begin
    reset                   = 1'b1;
    pc_fetch                = 32'h0;
    update_valid            = 1'b0;
    is_jump_execute         = 1'b0;
    pc_execute              = 32'h0;
    taken_execute           = 1'b0;
    target_execute          = 32'h0;
    predicted_taken_execute = 1'b0;
    predicted_pc_execute    = 32'h0;

    test_reset();
    test_allocate();
    test_hysteresis();
    test_aliasing();
    test_jump();
    test_saturation();
    test_reset_priority();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the pipelined RV hart: a direct-mapped branch target buffer with per-entry 2-bit saturating counters, parametrised in XLEN, entry count and performance-counter width. Fetch looks up the current PC combinationally and receives a predicted next PC. Execute reports each resolved branch or jump to train the table and to obtain a mispredict flag. The hazard unit uses that flag in place of plain branch-taken to flush decode/execute. Saturating branch and mispredict counters give visibility into predictor quality.

## Interface
- XLEN, 32, data/address width
- ENTRIES, 16, table entries; power of two, >= 2
- CNT_BITS, 32, width of each performance counter
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc_fetch  in  XLEN  PC being fetched this cycle
- predict_taken  out  1  fetch PC hits and its counter predicts taken
- predict_pc  out  XLEN  predicted next PC: stored target if predict_taken, else pc_fetch + 4
- update_valid  in  1  a branch or jump resolves in execute this cycle
- is_jump_execute  in  1  resolved instruction is JAL/JALR (always taken)
- pc_execute  in  XLEN  PC of the resolved instruction
- taken_execute  in  1  actual outcome
- target_execute  in  XLEN  actual target (valid when taken)
- predicted_taken_execute  in  1  predict_taken carried down the pipeline with the instruction
- predicted_pc_execute  in  XLEN  predict_pc carried down the pipeline
- mispredict  out  1  execute must redirect fetch
- branch_count  out  CNT_BITS  resolved updates since reset
- mispredict_count  out  CNT_BITS  mispredicts since reset

## Operation
- IDX = log2(ENTRIES). Index = pc[IDX+1:2]. Tag = pc[XLEN-1:IDX+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target[XLEN], ctr[2]. Counter encoding: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T.
- Lookup is purely combinational from registered state: hit = valid && tag match; predict_taken = hit && ctr[1]. The pc_fetch + 4 addition wraps modulo 2^XLEN.
- mispredict (combinational) = update_valid && (predicted_taken_execute != taken_execute || (taken_execute && predicted_pc_execute != target_execute)). It is 0 when update_valid = 0.
- Update on a clock edge with update_valid = 1, at the pc_execute index:
  - Hit, is_jump_execute: ctr := 3, target := target_execute.
  - Hit, conditional, taken: ctr := min(ctr+1, 3), target := target_execute.
  - Hit, not taken: ctr := max(ctr-1, 0); target unchanged.
  - Miss and taken: allocate (overwriting any resident entry). valid := 1, tag, target := target_execute, ctr := 3 if jump else 2.
  - Miss and not taken: no table change.
- Counters:
  - branch_count increments on every update_valid.
  - mispredict_count increments when mispredict = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Lookup latency 0 cycles (same-cycle combinational). Update is visible to lookup from the cycle after the edge.
- Lookup and update to the same index in the same cycle: lookup returns the pre-update contents. There is no bypass.
- Reset on a clock edge with reset = 1:
  - All valid := 0 and all ctr := 1.
  - Targets are don't-care.
  - branch_count and mispredict_count := 0.
  - Reset has priority over a concurrent update.
- Outputs after reset: predict_taken = 0, predict_pc = pc_fetch + 4. mispredict follows its inputs.
- Reset mid-operation discards all training. The first lookup after reset always predicts not-taken.

## Test plan
- Cold lookup:
  - Stimulus: reset, then pc_fetch = 0x100.
  - Required: predict_taken = 0, predict_pc = 0x104, both counters 0.
- Allocate and hit:
  - Stimulus: update_valid with pc_execute = 0x100, taken, target 0x80, conditional, predicted_taken_execute = 0, predicted_pc_execute = 0x104; next cycle pc_fetch = 0x100.
  - Required: mispredict = 1 in the update cycle; next cycle predict_taken = 1, predict_pc = 0x80; branch_count = 1, mispredict_count = 1.
- Hysteresis:
  - Stimulus: from weak-T, one not-taken update, then one taken update.
  - Required: predict_taken is 0 after the first update and 1 after the second. Three more taken updates keep ctr at 3. Two not-taken updates from 3 still leave predict_taken = 0 only after the second.
- Aliasing (ENTRIES = 16):
  - Stimulus: allocate pc 0x100, then allocate pc 0x140 (same index, different tag).
  - Required: lookup of 0x100 misses (predict_pc = 0x104); lookup of 0x140 hits.
- Jump target change:
  - Stimulus: JAL at 0x200 resolved with target 0x300, then JALR resolved with target 0x400, correctly predicted-taken with predicted_pc_execute 0x300.
  - Required: mispredict = 1 on the second update; lookup 0x200 then gives 0x400 with ctr = 3.
- Boundaries:
  - Stimulus: CNT_BITS = 4 with 20 mispredicting updates; separately, reset asserted together with update_valid.
  - Required: both counters hold at 15. In the reset case the table stays empty and the counters read 0.
  - Stimulus: pc_fetch = 0xFFFFFFFC with a miss. Required: predict_pc = 0x0.
